// File: rtl/obf_insnseq.sv
// Multi-cycle obfuscated-instruction sequencer: takes one reference instruction and walks the
// pseudo-PC through an external substitution LUT, emitting one obfuscated word per handshake.
module obf_insnseq #(
  parameter int PPC_WIDTH  = 4,
  parameter int KEY_WIDTH  = 8,
  parameter int TYPE_WIDTH = 2,
  parameter int MAX_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    obf_en,
  input  logic [KEY_WIDTH-1:0]    obf_key,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_insn,
  output logic [31:0]             lut_insn,
  output logic [PPC_WIDTH-1:0]    lut_ppc,
  output logic [KEY_WIDTH-1:0]    lut_key,
  input  logic [TYPE_WIDTH+12:0]  lut_sub,
  input  logic [15:0]             lut_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_insn,
  output logic [PPC_WIDTH-1:0]    out_ppc,
  output logic                    out_last,
  output logic                    out_skip,
  output logic                    err_len
);

  localparam logic [5:0] OPC_ALU   = 6'h38;
  localparam logic [5:0] OPC_MOVHI = 6'h06;
  localparam logic [5:0] OPC_RFE   = 6'h09;

  localparam logic [TYPE_WIDTH-1:0] TYPE_A = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] TYPE_I = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] TYPE_M = TYPE_WIDTH'(2);

  localparam logic [PPC_WIDTH-1:0] PPC_MAX = PPC_WIDTH'(MAX_LEN - 1);

  typedef enum logic {S_IDLE, S_GEN} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            ref_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [PPC_WIDTH-1:0]   ppc_q;
  logic                   en_q;

  logic [TYPE_WIDTH-1:0]  lut_type;
  logic [11:0]            lut_cmd;
  logic                   lut_last;
  logic                   at_max, eff_last;
  logic                   accept, advance, set_err;

  // Stores and non-immediate formats carry a split immediate around the rB field.
  function automatic logic [15:0] ref_imm(input logic [31:0] r);
    logic is_i;
    is_i = (r[31:30] == 2'b10) || (r[31:26] == OPC_MOVHI) || (r[31:26] == OPC_RFE);
    return is_i ? r[15:0] : {r[25:21], r[10:0]};
  endfunction

  function automatic logic [31:0] form_insn(input logic [TYPE_WIDTH-1:0] t,
                                            input logic [11:0] cmd,
                                            input logic [15:0] imm,
                                            input logic [31:0] r);
    logic [4:0]  d, a, b;
    logic [15:0] i;
    logic [31:0] w;
    d = cmd[3] ? 5'd0 : r[25:21];
    case (cmd[2:1])
      2'b00:   a = r[20:16];
      2'b01:   a = r[15:11];
      2'b10:   a = r[25:21];
      default: a = 5'd0;
    endcase
    b = cmd[0] ? 5'd0 : r[15:11];
    i = cmd[5] ? imm : (cmd[4] ? 16'd0 : ref_imm(r));
    if (t == TYPE_A)      w = {OPC_ALU, d, a, b, 1'b0, cmd[11:8], 2'b00, cmd[7:4]};
    else if (t == TYPE_I) w = {cmd[11:6], d, a, i};
    else if (t == TYPE_M) w = {cmd[11:6], i[15:11], a, b, i[10:0]};
    else                  w = r;
    return w;
  endfunction

  assign lut_type = lut_sub[TYPE_WIDTH+12:13];
  assign lut_cmd  = lut_sub[12:1];
  assign lut_last = lut_sub[0];

  assign at_max   = (ppc_q == PPC_MAX);
  assign eff_last = (en_q ? lut_last : 1'b1) | at_max;

  assign lut_insn = ref_q;
  assign lut_ppc  = ppc_q;
  assign lut_key  = key_q;

  assign out_insn = en_q ? form_insn(lut_type, lut_cmd, lut_imm, ref_q) : ref_q;
  assign out_ppc  = ppc_q;
  assign out_last = eff_last;
  assign out_skip = en_q & ((lut_type == TYPE_I) | (lut_type == TYPE_M)) & lut_cmd[5];

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept  = 1'b1;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        out_valid = 1'b1;
        in_ready  = out_ready & eff_last & ~flush;
        if (out_ready && !flush) begin
          if (eff_last) begin
            set_err = en_q & ~lut_last & at_max;
            if (in_valid) accept = 1'b1;
            else          state_d = S_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides everything, including a simultaneous output or input handshake.
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ref_q   <= '0;
      key_q   <= '0;
      ppc_q   <= '0;
      en_q    <= 1'b0;
      err_len <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ref_q <= in_insn;
        key_q <= obf_key;
        en_q  <= obf_en;
        ppc_q <= '0;
      end else if (advance) begin
        ppc_q <= ppc_q + PPC_WIDTH'(1);
      end
      if (set_err) err_len <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obf_insnseq.sv
// Bench for obf_insnseq: table of single-step substitutions plus hand-built multi-cycle
// sequences (stall, watchdog, back-to-back, flush, reset), checked through an expectation queue.
module tb_obf_insnseq;

  localparam int PW = 4;
  localparam int KW = 8;
  localparam int TW = 2;
  localparam int ML = 8;

  localparam logic [1:0] T_A = 2'd0;
  localparam logic [1:0] T_I = 2'd1;
  localparam logic [1:0] T_M = 2'd2;
  localparam logic [1:0] T_N = 2'd3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           obf_en = 1'b0;
  logic [KW-1:0]  obf_key = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [31:0]    in_insn = '0;
  logic [31:0]    lut_insn;
  logic [PW-1:0]  lut_ppc;
  logic [KW-1:0]  lut_key;
  logic [TW+12:0] lut_sub;
  logic [15:0]    lut_imm;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [31:0]    out_insn;
  logic [PW-1:0]  out_ppc;
  logic           out_last;
  logic           out_skip;
  logic           err_len;

  logic [TW+12:0] sub_tab [16];
  logic [15:0]    imm_tab [16];

  assign lut_sub = sub_tab[lut_ppc];
  assign lut_imm = imm_tab[lut_ppc];

  obf_insnseq #(.PPC_WIDTH(PW), .KEY_WIDTH(KW), .TYPE_WIDTH(TW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .obf_en(obf_en), .obf_key(obf_key),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .lut_insn(lut_insn), .lut_ppc(lut_ppc), .lut_key(lut_key),
    .lut_sub(lut_sub), .lut_imm(lut_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_ppc(out_ppc), .out_last(out_last), .out_skip(out_skip), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] insn;
    logic        en;
    logic [1:0]  typ;
    logic [11:0] cmd;
    logic [15:0] imm;
    logic [31:0] exp_insn;
    logic        exp_skip;
  } vec_t;

  typedef struct packed {
    logic [31:0]   insn;
    logic [PW-1:0] ppc;
    logic          last;
    logic          skip;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_lut();
    for (int i = 0; i < 16; i++) begin
      sub_tab[i] = {T_N, 12'h000, 1'b0};
      imm_tab[i] = 16'h0000;
    end
  endtask

  task automatic set_lut(input int p, input logic [1:0] t, input logic [11:0] c,
                         input logic [15:0] imm, input logic last);
    sub_tab[p] = {t, c, last};
    imm_tab[p] = imm;
  endtask

  task automatic push_exp(input logic [31:0] insn, input int p, input logic last, input logic skip);
    exp_t e;
    e.insn = insn;
    e.ppc  = PW'(p);
    e.last = last;
    e.skip = skip;
    sb.push_back(e);
  endtask

  task automatic cmp_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_extra actual_insn=%h required=no_output", tag, out_insn);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_insn"}, out_insn, e.insn);
    chk({tag, "_ppc"},  32'(out_ppc), 32'(e.ppc));
    chk({tag, "_last"}, 32'(out_last), 32'(e.last));
    chk({tag, "_skip"}, 32'(out_skip), 32'(e.skip));
  endtask

  // Returns at the negedge of the n-th consumed output; that handshake completes at the next posedge.
  task automatic run_out(input string tag, input int n, input int budget, output int used);
    int got;
    got  = 0;
    used = 0;
    while (got < n && used < budget) begin
      @(negedge clk);
      used++;
      if (out_valid && out_ready) begin
        cmp_pop(tag);
        got++;
      end
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout outputs=%0d required=%0d", tag, got, n);
    end
  endtask

  task automatic send(input string tag, input logic [31:0] insn, input logic en, input logic [KW-1:0] key);
    int n;
    in_insn  = insn;
    obf_en   = en;
    obf_key  = key;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept in_ready=0 required=1", tag);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_lut_insn"}, lut_insn, insn);
    chk({tag, "_lut_key"}, 32'(lut_key), 32'(key));
  endtask

  task automatic load_seq3();
    clear_lut();
    set_lut(0, T_N, 12'h000, 16'h0000, 1'b0);
    set_lut(1, T_A, 12'hA52, 16'h0000, 1'b0);
    set_lut(2, T_I, 12'hA2C, 16'hBEEF, 1'b1);
  endtask

  task automatic push_seq3();
    push_exp(32'hE0621800, 0, 1'b0, 1'b0);
    push_exp(32'hE0631A85, 1, 1'b0, 1'b0);
    push_exp(32'hA003BEEF, 2, 1'b1, 1'b1);
  endtask

  initial begin
    int used;

    vt[0] = '{32'hE0621800, 1'b0, T_A, 12'hFFF, 16'h0000, 32'hE0621800, 1'b0};
    vt[1] = '{32'h12345678, 1'b1, T_N, 12'hFFF, 16'h5555, 32'h12345678, 1'b0};
    vt[2] = '{32'hE0621800, 1'b1, T_A, 12'hA52, 16'h0000, 32'hE0631A85, 1'b0};
    vt[3] = '{32'h9C811234, 1'b1, T_I, 12'hA2C, 16'hBEEF, 32'hA004BEEF, 1'b1};
    vt[4] = '{32'hD6A74923, 1'b1, T_M, 12'hD81, 16'hFFFF, 32'hDAA70123, 1'b0};
    vt[5] = '{32'h1940CAFE, 1'b1, T_I, 12'h846, 16'h0000, 32'h8540CAFE, 1'b0};
    vt[6] = '{32'hD6A74923, 1'b1, T_M, 12'hD62, 16'h8421, 32'hD6094C21, 1'b1};
    vt[7] = '{32'h2400F00F, 1'b1, T_I, 12'h9CE, 16'h1111, 32'h9C00F00F, 1'b0};
    clear_lut();

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_ppc", 32'(lut_ppc), 32'd0);
    chk("rst_insn", lut_insn, 32'd0);
    chk("rst_key", 32'(lut_key), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    for (int v = 0; v < 8; v++) begin
      clear_lut();
      set_lut(0, vt[v].typ, vt[v].cmd, vt[v].imm, vt[v].en);
      push_exp(vt[v].exp_insn, 0, 1'b1, vt[v].exp_skip);
      send($sformatf("vec%0d", v), vt[v].insn, vt[v].en, KW'(8'h30 + v));
      run_out($sformatf("vec%0d", v), 1, 10, used);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("vec_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    load_seq3();
    push_seq3();
    send("seq3", 32'hE0621800, 1'b1, 8'h5A);
    run_out("seq3", 3, 20, used);
    chk("seq3_cycles", used, 32'd3);
    @(posedge clk);
    #1;

    push_seq3();
    send("stall", 32'hE0621800, 1'b1, 8'hC3);
    run_out("stall", 1, 10, used);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_ppc", k), 32'(out_ppc), 32'd1);
      chk($sformatf("stall%0d_insn", k), out_insn, 32'hE0631A85);
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    run_out("stall", 2, 10, used);
    @(posedge clk);
    #1;

    clear_lut();
    chk("wd_err_before", 32'(err_len), 32'd0);
    for (int p = 0; p < ML; p++) push_exp(32'hA5A55A5A, p, p == ML - 1, 1'b0);
    send("wd", 32'hA5A55A5A, 1'b1, 8'h11);
    run_out("wd", ML, 40, used);
    @(posedge clk);
    #1;
    chk("wd_err_set", 32'(err_len), 32'd1);
    @(negedge clk);
    chk("wd_idle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    push_exp(32'h0BADF00D, 0, 1'b1, 1'b0);
    send("wd_after", 32'h0BADF00D, 1'b0, 8'h22);
    run_out("wd_after", 1, 10, used);
    @(posedge clk);
    #1;
    chk("wd_err_sticky", 32'(err_len), 32'd1);

    clear_lut();
    set_lut(0, T_N, 12'h000, 16'h0000, 1'b1);
    push_exp(32'h11111111, 0, 1'b1, 1'b0);
    push_exp(32'h22222222, 0, 1'b1, 1'b0);
    obf_en   = 1'b1;
    in_insn  = 32'h11111111;
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_insn = 32'h22222222;
    @(negedge clk);
    chk("b2b_ready_in_gen", 32'(in_ready), 32'd1);
    chk("b2b_valid1", 32'(out_valid), 32'd1);
    cmp_pop("b2b1");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid2", 32'(out_valid), 32'd1);
    cmp_pop("b2b2");
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b2b_idle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    load_seq3();
    push_seq3();
    send("flush", 32'hE0621800, 1'b1, 8'h77);
    run_out("flush", 1, 10, used);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_at_ppc", 32'(out_ppc), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    push_seq3();
    send("rstmid", 32'hE0621800, 1'b1, 8'h99);
    run_out("rstmid", 1, 10, used);
    @(posedge clk);
    #1;
    chk("rstmid_ppc_before", 32'(lut_ppc), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_ppc", 32'(lut_ppc), 32'd0);
    chk("rstmid_err_len", 32'(err_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(32'hE0621800, 0, 1'b1, 1'b0);
    send("post_rst", 32'hE0621800, 1'b0, 8'h00);
    run_out("post_rst", 1, 10, used);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
